reg_dump_tx: RTL and testbench
==============================

Name: reg_dump_tx

Overview:
- Reader/observer on the output side of the CPU register file.
- Watches the 16-bit `result` (r2) and `counter` (r3) observation words.
- Serialises them to a host over a UART 8N1 line as a 5-byte frame: sync, result hi, result lo, counter hi, counter lo.
- Sends on any value change (when enabled) or on explicit trigger; lets the board report program results without a debugger.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- result  input  16  register-file result word (r2).
- counter  input  16  register-file counter word (r3).
- auto_en  input  1  1 = send a frame automatically when result or counter changes.
- trig  input  1  1-cycle request to send a frame regardless of change.
- txd  output  1  UART serial out, idle high.
- busy  output  1  1 while a frame is on the line.
- frame_cnt  output  8  count of completed frames, wraps 255->0.

Behaviour:
Reset (rst=0, async):
- txd=1, busy=0, frame_cnt=0, pending=0, state=IDLE.
- Previous-value registers prev_r=prev_c=0. The register file also resets to 0, so reset alone never triggers a frame.

Change detect, every cycle:
- chg = (result!=prev_r) | (counter!=prev_c).
- prev_r/prev_c load result/counter every cycle.
- req = trig | (auto_en & chg).

Request handling:
- State IDLE and req at edge k: snapshot result/counter into shadow regs at edge k, enter START for byte 0, drive txd=0 and busy=1 from edge k. Latency is 1 edge.
- Not IDLE and req: set pending=1. Multiple requests collapse into one pending.
- IDLE with pending=1: treated as req, pending cleared. The snapshot is taken at that frame start, so the latest values are sent and intermediate values are dropped.

Per-byte FSM, states START, DATA, STOP:
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
- STOP: txd=1 for CLKS_PER_BIT cycles.
- Bit timer counts 0..CLKS_PER_BIT-1; the bit advances when timer==CLKS_PER_BIT-1.
- Byte index 0..4 selects SYNC_BYTE, shadow_r[15:8], shadow_r[7:0], shadow_c[15:8], shadow_c[7:0].
- End of STOP with index<4: index+1, go to START (no idle gap).
- End of STOP with index==4: go to IDLE, busy=0, frame_cnt+1.

Frame length and spacing:
- A frame is exactly 50*CLKS_PER_BIT cycles of busy=1.
- Back-to-back frames are separated by exactly one IDLE cycle with txd=1, busy=0.

Input sampling:
- Shadow registers are stable for the whole frame. Input changes mid-frame never corrupt the frame in flight.
- trig and change in the same cycle produce one frame.
- auto_en=0 ignores changes but still updates prev_*. Re-enabling does not send stale changes.

Reset mid-frame:
- txd returns to 1 immediately (async), frame is abandoned, pending lost, frame_cnt=0.

Test Plan (CLKS_PER_BIT=4):
1. Reset, hold inputs 0, auto_en=1 for 500 cycles -> txd stays 1, busy=0, frame_cnt=0.
2. result=16'h1234, counter=16'h00FF, pulse trig -> txd decodes A5 12 34 00 FF, LSB first. Start bit low from the edge after trig. busy high exactly 200 cycles. frame_cnt=1.
3. auto_en=1, counter steps 1->2->3 during a frame -> exactly one extra frame after 1 idle cycle, carrying counter=3. frame_cnt +2 total.
4. auto_en=0, change result to 16'hBEEF, wait, then set auto_en=1 with no further change -> no frame. Then pulse trig -> frame with result bytes BE EF.
5. Assert rst=0 during byte 2 -> txd=1 and busy=0 asynchronously, frame_cnt=0. After release with no req, the line stays idle.
6. 256 triggered frames -> frame_cnt wraps to 0. Every frame begins with A5.

Source files
------------

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: observes the register-file result (r2) and counter (r3) words
// and sends them to a host as a 5-byte UART 8N1 frame:
//   SYNC_BYTE, result[15:8], result[7:0], counter[15:8], counter[7:0].
// A frame is sent when trig pulses, or when either word changes and auto_en
// is set. Requests that arrive mid-frame collapse into one pending frame.
// That frame snapshots the values current at its own start.
module reg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic [15:0] counter,
    input  logic        auto_en,
    input  logic        trig,
    output logic        txd,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BYTE = 3'd4;
    localparam logic [2:0]  LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state, state_next;
    logic [15:0] timer, timer_next;
    logic [2:0]  bit_idx, bit_next;
    logic [2:0]  byte_idx, byte_next;
    logic [15:0] shadow_r, shadow_r_next;
    logic [15:0] shadow_c, shadow_c_next;
    logic        pending, pending_next;
    logic [7:0]  cnt_next;
    logic        txd_next;
    logic        busy_next;
    logic [15:0] prev_r, prev_c;
    logic        chg;
    logic        req;
    logic        bit_done;
    logic [7:0]  tx_byte;

    // Byte index 0..4 selects the frame byte from the sync constant and shadows.
    function automatic logic [7:0] byte_sel(input logic [2:0]  idx,
                                            input logic [15:0] sr,
                                            input logic [15:0] sc);
        logic [7:0] b;
        case (idx)
            3'd1:    b = sr[15:8];
            3'd2:    b = sr[7:0];
            3'd3:    b = sc[15:8];
            3'd4:    b = sc[7:0];
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

    // Previous-value registers track the inputs every cycle, even when
    // auto_en is low, so re-enabling never replays a stale change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r <= '0;
            prev_c <= '0;
        end else begin
            prev_r <= result;
            prev_c <= counter;
        end
    end

    // Change detection and request qualification.
    always_comb begin
        chg = (result != prev_r) || (counter != prev_c);
        req = trig || (auto_en && chg);
    end

    // State, datapath and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shadow_r  <= '0;
            shadow_c  <= '0;
            pending   <= 1'b0;
            frame_cnt <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_idx   <= bit_next;
            byte_idx  <= byte_next;
            shadow_r  <= shadow_r_next;
            shadow_c  <= shadow_c_next;
            pending   <= pending_next;
            frame_cnt <= cnt_next;
            txd       <= txd_next;
            busy      <= busy_next;
        end
    end

    // Next-state logic. txd and busy are derived from the next state so
    // they are registered and change on the same edge as the state.
    always_comb begin
        state_next    = state;
        timer_next    = timer;
        bit_next      = bit_idx;
        byte_next     = byte_idx;
        shadow_r_next = shadow_r;
        shadow_c_next = shadow_c;
        pending_next  = pending;
        cnt_next      = frame_cnt;
        txd_next      = 1'b1;
        busy_next     = 1'b0;
        tx_byte       = '0;
        bit_done      = (timer == BIT_LAST);

        if (state != IDLE) begin
            pending_next = pending || req;
        end

        case (state)
            IDLE: begin
                if (req || pending) begin
                    shadow_r_next = result;
                    shadow_c_next = counter;
                    state_next    = START;
                    byte_next     = '0;
                    bit_next      = '0;
                    timer_next    = '0;
                    pending_next  = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_next = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_next = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_next = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_next = IDLE;
                        cnt_next   = frame_cnt + 8'd1;
                    end else begin
                        byte_next  = byte_idx + 3'd1;
                        state_next = START;
                    end
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        tx_byte = byte_sel(byte_next, shadow_r_next, shadow_c_next);
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = tx_byte[bit_next];
            default: txd_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Testbench for reg_dump_tx: per-cycle comparison against a frame-timing
// model, table-driven triggered frames, and directed multi-cycle sequences.
module tb_reg_dump_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 50 * CPB;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk;
    logic        rst;
    logic [15:0] result;
    logic [15:0] counter;
    logic        auto_en;
    logic        trig;
    logic        txd;
    logic        busy;
    logic [7:0]  frame_cnt;

    int tests;
    int failed;

    // Reference model: frame start times and snapshots, by arithmetic.
    logic [15:0] m_prev_r, m_prev_c, m_sr, m_sc;
    bit          m_active, m_pend;
    int          m_edge, m_start, m_end, m_done, m_started;

    logic cap  [0:1023];
    logic capb [0:1023];

    typedef struct {
        logic        au;
        logic [15:0] r;
        logic [15:0] c;
        logic [39:0] exp_bytes;
        int          exp_busy;
    } vec_t;

    vec_t vt [4];

    reg_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .result(result),
        .counter(counter),
        .auto_en(auto_en),
        .trig(trig),
        .txd(txd),
        .busy(busy),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_r  = '0;
        m_prev_c  = '0;
        m_sr      = '0;
        m_sc      = '0;
        m_active  = 0;
        m_pend    = 0;
        m_edge    = 0;
        m_start   = 0;
        m_end     = 0;
        m_done    = 0;
        m_started = 0;
    endtask

    task automatic model_step();
        bit req;
        bit was_idle;
        m_edge++;
        req = trig || (auto_en && (result != m_prev_r || counter != m_prev_c));
        m_prev_r = result;
        m_prev_c = counter;
        was_idle = !m_active;
        if (m_active && m_edge == m_end) begin
            m_active = 0;
            m_done++;
        end
        if (was_idle && (req || m_pend)) begin
            m_active = 1;
            m_pend   = 0;
            m_start  = m_edge;
            m_end    = m_edge + FRAME;
            m_sr     = result;
            m_sc     = counter;
            m_started++;
        end else if (!was_idle && req) begin
            m_pend = 1;
        end
    endtask

    function automatic logic exp_txd();
        logic [7:0] fb [5];
        logic [7:0] bv;
        int off, bitn, pos;
        if (!m_active) return 1'b1;
        fb[0] = SYNC;
        fb[1] = m_sr[15:8];
        fb[2] = m_sr[7:0];
        fb[3] = m_sc[15:8];
        fb[4] = m_sc[7:0];
        off  = m_edge - m_start;
        bitn = off / CPB;
        pos  = bitn % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        bv = fb[bitn / 10];
        return bv[pos - 1];
    endfunction

    task automatic tick();
        logic [9:0] exp_v;
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        #1;
        exp_v = {exp_txd(), m_active, 8'(m_done)};
        check("cycle_outputs", 64'({txd, busy, frame_cnt}), 64'(exp_v));
    endtask

    task automatic capture_frame(input bit pulse, output int start_idx,
                                 output int busy_len, output logic [39:0] bytes);
        int n;
        int idx;
        bit seen;
        bit done;
        n = 0;
        seen = 0;
        done = 0;
        if (pulse) trig = 1'b1;
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            if (pulse && i == 0) trig = 1'b0;
            cap[n]  = txd;
            capb[n] = busy;
            n++;
            if (busy) seen = 1;
            else if (seen) done = 1;
        end
        trig = 1'b0;
        check("frame_done_in_time", 64'(done), 64'd1);
        start_idx = -1;
        busy_len  = 0;
        for (int i = 0; i < n; i++) begin
            if (capb[i]) begin
                if (start_idx < 0) start_idx = i;
                busy_len++;
            end
        end
        bytes = '0;
        if (start_idx >= 0) begin
            for (int b = 0; b < 5; b++) begin
                for (int j = 0; j < 8; j++) begin
                    idx = start_idx + (b * 10 + 1 + j) * CPB + CPB / 2;
                    if (idx < n) bytes[(4 - b) * 8 + j] = cap[idx];
                end
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int quiet;
        quiet = 0;
        for (int i = 0; i < max_cycles && quiet < 3; i++) begin
            tick();
            if (busy) quiet = 0;
            else quiet++;
        end
        check("idle_in_time", 64'(quiet >= 3), 64'd1);
    endtask

    initial begin
        int s, bl, starts, rel;
        logic [39:0] by;
        logic [7:0] sb;
        logic prev_busy;

        tests  = 0;
        failed = 0;
        vt[0] = '{au: 1'b0, r: 16'h1234, c: 16'h00FF, exp_bytes: 40'hA5_12_34_00_FF, exp_busy: FRAME};
        vt[1] = '{au: 1'b1, r: 16'hFFFF, c: 16'h0000, exp_bytes: 40'hA5_FF_FF_00_00, exp_busy: FRAME};
        vt[2] = '{au: 1'b0, r: 16'h0000, c: 16'h8001, exp_bytes: 40'hA5_00_00_80_01, exp_busy: FRAME};
        vt[3] = '{au: 1'b1, r: 16'hA55A, c: 16'h5AA5, exp_bytes: 40'hA5_A5_5A_5A_A5, exp_busy: FRAME};

        // 1: reset, then idle with zero inputs and auto_en=1
        rst = 1'b0;
        result = '0;
        counter = '0;
        auto_en = 1'b1;
        trig = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_txd", 64'(txd), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b1;
        repeat (500) tick();
        check("idle_txd", 64'(txd), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_cnt", 64'(frame_cnt), 64'd0);

        // 2: table of triggered frames (entries 1 and 3 also change with auto_en=1)
        for (int v = 0; v < 4; v++) begin
            auto_en = vt[v].au;
            result  = vt[v].r;
            counter = vt[v].c;
            capture_frame(1'b1, s, bl, by);
            check("tbl_start_latency", 64'(s), 64'd0);
            check("tbl_busy_len", 64'(bl), 64'(vt[v].exp_busy));
            check("tbl_bytes", 64'(by), 64'(vt[v].exp_bytes));
            repeat (5) tick();
            check("tbl_single_frame", 64'(busy), 64'd0);
        end
        check("tbl_cnt", 64'(frame_cnt), 64'd4);

        // 3: counter steps during a frame collapse into one follow-up frame
        counter = 16'h0001;
        tick();
        check("t3_start", 64'(busy), 64'd1);
        repeat (40) tick();
        counter = 16'h0002;
        repeat (40) tick();
        counter = 16'h0003;
        for (int i = 0; i < 400 && busy; i++) tick();
        check("t3_first_end", 64'(busy), 64'd0);
        capture_frame(1'b0, s, bl, by);
        check("t3_one_idle_gap", 64'(s), 64'd0);
        check("t3_busy_len", 64'(bl), 64'(FRAME));
        check("t3_bytes", 64'(by), 64'hA5_A5_5A_00_03);
        repeat (5) tick();
        check("t3_no_third", 64'(busy), 64'd0);
        check("t3_cnt", 64'(frame_cnt), 64'd6);

        // 4: change while auto_en=0 is not replayed on re-enable
        auto_en = 1'b0;
        result = 16'hBEEF;
        repeat (20) tick();
        auto_en = 1'b1;
        repeat (20) tick();
        check("t4_no_stale", 64'(busy), 64'd0);
        check("t4_cnt_hold", 64'(frame_cnt), 64'd6);
        capture_frame(1'b1, s, bl, by);
        check("t4_bytes", 64'(by), 64'hA5_BE_EF_00_03);
        check("t4_cnt", 64'(frame_cnt), 64'd7);

        // 5: async reset in byte 2
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (89) tick();
        check("t5_midframe_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_txd", 64'(txd), 64'd1);
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_cnt", 64'(frame_cnt), 64'd0);
        model_reset();
        result = '0;
        counter = '0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (300) tick();
        check("t5_stays_idle", 64'(busy), 64'd0);
        check("t5_cnt", 64'(frame_cnt), 64'd0);

        // 6: 256 back-to-back frames, each starting with the sync byte
        starts = 0;
        rel = 0;
        sb = '0;
        prev_busy = busy;
        trig = 1'b1;
        for (int i = 0; i < 60000 && m_started < 256; i++) begin
            tick();
            if (m_started >= 256) trig = 1'b0;
            if (busy && !prev_busy) begin
                starts++;
                rel = 0;
            end else begin
                rel++;
            end
            if (busy && rel >= CPB + CPB / 2 && rel < 9 * CPB && (rel - CPB / 2) % CPB == 0)
                sb[(rel - CPB / 2) / CPB - 1] = txd;
            if (busy && rel == 9 * CPB + CPB / 2) check("t6_sync_byte", 64'(sb), 64'(SYNC));
            prev_busy = busy;
        end
        trig = 1'b0;
        for (int i = 0; i < 400 && busy; i++) tick();
        check("t6_starts", 64'(starts), 64'd256);
        check("t6_wrap_cnt", 64'(frame_cnt), 64'd0);

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(49) == 0) result = 16'($urandom);
            if ($urandom_range(59) == 0) counter = 16'($urandom);
            if ($urandom_range(299) == 0) auto_en = ~auto_en;
            trig = ($urandom_range(99) == 0);
            tick();
        end
        trig = 1'b0;
        auto_en = 1'b0;
        wait_idle(1000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
